// File: rtl/uart_trx.sv
// Full-duplex UART: 2-flop synchronised mid-bit RX, valid/ready TX, fixed divisor.
// Optional parity via UART_PARITY_EN (PARITY_ODD selects sense); default build has no parity bit.
module uart_trx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_overrun_o,
  output logic                 rx_parity_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_rx_state;
  logic                 r_sync1, r_sync2;
  logic [CW-1:0]        r_rx_cnt;
  logic [BW-1:0]        r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_overrun, r_parity_err;
  logic                 w_rx_tick, w_par_bad;

  assign w_rx_tick = (r_rx_cnt == LAST);

`ifdef UART_PARITY_EN
  logic r_rx_par;
  assign w_par_bad = r_rx_par != ((^r_rx_shift) ^ 1'(PARITY_ODD));
`else
  logic w_unused_par;
  assign w_unused_par = (PARITY_ODD != 0);
  assign w_par_bad    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par     <= 1'b0;
`endif
    end else begin
      r_sync1      <= rx_i;
      r_sync2      <= r_sync1;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
      if (rx_ready_i) r_rx_valid <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_rx_state <= S_START;
            r_rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_rx_cnt == HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_sync2 ? S_IDLE : S_DATA;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
`ifdef UART_PARITY_EN
            if (r_rx_bit == LAST_BIT) r_rx_state <= S_PARITY;
`else
            if (r_rx_bit == LAST_BIT) r_rx_state <= S_STOP;
`endif
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_PARITY: begin
`ifdef UART_PARITY_EN
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_par   <= r_sync2;
            r_rx_state <= S_STOP;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
`else
          r_rx_state <= S_IDLE;
`endif
        end
        S_STOP: begin
          if (w_rx_tick) begin
            r_rx_cnt     <= '0;
            r_rx_state   <= S_IDLE;
            r_frame_err  <= ~r_sync2;
            r_parity_err <= w_par_bad;
            // A completing byte beats a same-cycle read, so valid stays set.
            if (r_sync2 && !w_par_bad) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              r_overrun  <= r_rx_valid & ~rx_ready_i;
            end
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data_o       = r_rx_data;
  assign rx_valid_o      = r_rx_valid;
  assign rx_frame_err_o  = r_frame_err;
  assign rx_overrun_o    = r_overrun;
  assign rx_parity_err_o = r_parity_err;

  state_t               r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_bit;
  logic                 r_tx_stop;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx, r_tx_ready;
  logic                 w_tx_tick, w_tx_accept;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_tick   = (r_tx_cnt == LAST);
  assign w_tx_accept = tx_valid_i & r_tx_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else if (w_tx_accept) begin
      r_tx_shift <= tx_data_i;
`ifdef UART_PARITY_EN
      r_tx_par   <= (^tx_data_i) ^ 1'(PARITY_ODD);
`endif
      r_tx       <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_state <= S_START;
    end else begin
      case (r_tx_state)
        S_START: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= r_tx_bit + 1'b1;
            r_tx_shift <= r_tx_shift >> 1;
            r_tx       <= r_tx_shift[1];
            if (r_tx_bit == LAST_BIT) begin
              r_tx_stop <= 1'b0;
`ifdef UART_PARITY_EN
              r_tx       <= r_tx_par;
              r_tx_state <= S_PARITY;
`else
              r_tx       <= 1'b1;
              r_tx_state <= S_STOP;
`endif
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_PARITY: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx       <= 1'b1;
            r_tx_state <= S_STOP;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_STOP: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_stop == LAST_STOP) r_tx_state <= S_IDLE;
            else r_tx_stop <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
            // Ready for the final cycle so a queued byte follows with no idle gap.
            if (r_tx_cnt == PRE_LAST && r_tx_stop == LAST_STOP) r_tx_ready <= 1'b1;
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_o       = r_tx;
  assign tx_ready_o = r_tx_ready;

endmodule

// File: tb/tb_uart_trx.sv
// Self-checking bench for uart_trx with CLKS_PER_BIT=16, 8 data bits, 1 stop bit.
module tb_uart_trx;
  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DW + P + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_i;
  logic          tx_o;
  logic [DW-1:0] tx_data_i = '0;
  logic          tx_valid_i = 1'b0;
  logic          tx_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i = 1'b1;
  logic          rx_frame_err_o, rx_overrun_o, rx_parity_err_o;

  logic r_loop = 1'b0;
  logic r_rx_drv = 1'b1;
  assign rx_i = r_loop ? tx_o : r_rx_drv;

  uart_trx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .tx_o(tx_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_frame_err_o(rx_frame_err_o), .rx_overrun_o(rx_overrun_o),
    .rx_parity_err_o(rx_parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic [DW-1:0] rxq[$];

  // Event monitor: error pulses and bytes actually handed to the consumer.
  always @(negedge clk_i) begin
    if (rx_frame_err_o)  n_ferr++;
    if (rx_overrun_o)    n_ovr++;
    if (rx_parity_err_o) n_perr++;
    if (rx_valid_o && rx_ready_i) rxq.push_back(rx_data_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_of(input logic [DW-1:0] d);
    return ^d;
  endfunction

  // Line level k cycles after the start bit begins, from the frame layout.
  function automatic logic exp_line(input logic [DW-1:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (P == 1 && b == DW + 1) return par_of(d);
    return 1'b1;
  endfunction

  task automatic tx_frame_check(input logic [DW-1:0] d, input string tag);
    int mism, low;
    mism = 0;
    low  = 0;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    for (int k = 0; k < NBITS * CPB; k++) begin
      if (tx_o !== exp_line(d, k)) mism++;
      if (!tx_ready_o) low++;
      @(negedge clk_i);
    end
    check({tag, "_bits"}, mism, 0);
    check({tag, "_ready_low"}, low, NBITS * CPB - 1);
    check({tag, "_idle_tx"}, tx_o, 1'b1);
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    int t;
    t = 0;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    while (!tx_ready_o && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 1000) check("tx_ready_timeout", t, 0);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  task automatic drive_rx_frame(input logic [DW-1:0] d, input logic stop, input logic par);
    r_rx_drv = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < DW; i++) begin
      r_rx_drv = d[i];
      repeat (CPB) @(negedge clk_i);
    end
    if (P == 1) begin
      r_rx_drv = par;
      repeat (CPB) @(negedge clk_i);
    end
    r_rx_drv = stop;
    repeat (CPB) @(negedge clk_i);
    r_rx_drv = 1'b1;
    repeat (CPB) @(negedge clk_i);
  endtask

  initial begin
    logic [DW-1:0] exp_bytes[$];
    logic [DW-1:0] a, b;

    repeat (3) @(negedge clk_i);
    check("rst_tx", tx_o, 1'b1);
    check("rst_ready", tx_ready_o, 1'b1);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_errs", {rx_frame_err_o, rx_overrun_o, rx_parity_err_o}, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    tx_frame_check(8'hA5, "tx_a5");
    tx_frame_check(8'($urandom_range(0, 255)), "tx_rand");

    // Loopback, back-to-back transmission.
    r_loop = 1'b1;
    rxq.delete();
    exp_bytes = '{8'h00, 8'hFF, 8'h3C};
    repeat (3) exp_bytes.push_back(8'($urandom_range(0, 255)));
    foreach (exp_bytes[i]) send_tx(exp_bytes[i]);
    repeat (NBITS * CPB + 40) @(negedge clk_i);
    check("loop_count", rxq.size(), exp_bytes.size());
    foreach (exp_bytes[i])
      if (i < rxq.size()) check($sformatf("loop_byte%0d", i), rxq[i], exp_bytes[i]);
    check("loop_errs", n_ferr + n_ovr + n_perr, 0);
    r_loop = 1'b0;
    repeat (4) @(negedge clk_i);

    // Start-bit glitch, then a clean frame.
    rxq.delete();
    r_rx_drv = 1'b0;
    repeat (5) @(negedge clk_i);
    r_rx_drv = 1'b1;
    repeat (40) @(negedge clk_i);
    check("glitch_valid", rxq.size(), 0);
    check("glitch_ferr", n_ferr, 0);
    drive_rx_frame(8'h42, 1'b1, par_of(8'h42));
    check("post_glitch_count", rxq.size(), 1);
    if (rxq.size() > 0) check("post_glitch_byte", rxq[0], 8'h42);

    // Framing error.
    drive_rx_frame(8'h55, 1'b0, par_of(8'h55));
    repeat (CPB) @(negedge clk_i);
    check("frame_err_pulses", n_ferr, 1);
    check("frame_err_no_byte", rxq.size(), 1);
    check("frame_err_valid", rx_valid_o, 1'b0);

    // Overrun with the consumer stalled.
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    rx_ready_i = 1'b0;
    drive_rx_frame(a, 1'b1, par_of(a));
    check("ovr_first_valid", rx_valid_o, 1'b1);
    check("ovr_first_data", rx_data_o, a);
    check("ovr_first_pulse", n_ovr, 0);
    drive_rx_frame(b, 1'b1, par_of(b));
    check("ovr_pulse", n_ovr, 1);
    check("ovr_data", rx_data_o, b);
    check("ovr_valid", rx_valid_o, 1'b1);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    check("ovr_valid_clear", rx_valid_o, 1'b0);
    rxq.delete();

    // Reset in the middle of data bit 3.
    tx_data_i  = 8'($urandom_range(0, 255));
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    repeat (4 * CPB + 5) @(negedge clk_i);
    check("midtx_busy", tx_ready_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midtx_rst_tx", tx_o, 1'b1);
    check("midtx_rst_ready", tx_ready_o, 1'b1);
    rst_i = 1'b0;
    repeat (NBITS * CPB) @(negedge clk_i);
    check("midtx_idle_tx", tx_o, 1'b1);

`ifdef UART_PARITY_EN
    drive_rx_frame(8'h07, 1'b1, 1'b0);
    check("parity_err_pulses", n_perr, 1);
    check("parity_err_no_byte", rxq.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
